// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - push and serial-line signal bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_BITS-1:0] Din;
    logic                 Din_Valid;
    logic                 Din_Ready;
    logic                 Serial_Out;
    logic                 UBusy;
    logic [CW-1:0]        Fifo_Count;
    logic                 Frame_Done;

    modport master (
        output Din, Din_Valid,
        input  Din_Ready, Serial_Out, UBusy, Fifo_Count, Frame_Done
    );

    modport slave (
        input  Din, Din_Valid,
        output Din_Ready, Serial_Out, UBusy, Fifo_Count, Frame_Done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with configurable frame format
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    uart_tx_fifo_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = 4;

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_fifo: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;

    state_t               state_q;
    logic [BW-1:0]        baud_q;
    logic [IW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q, serial_q, busy_q, done_q;

    logic                 ready, push, pop, nonempty, baud_end, last_stop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    assign ready     = (count_q != CW'(FIFO_DEPTH));
    assign push      = bus.Din_Valid && ready;
    assign nonempty  = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign head_par  = (^head) ^ (PARITY_MODE == 2);
    assign baud_end  = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign last_stop = (bit_q == IW'(STOP_BITS - 1));
    // Pop either from idle or at the very end of a frame so the next start bit follows with no gap.
    assign pop       = nonempty && ((state_q == S_IDLE) ||
                                    (state_q == S_STOP && baud_end && last_stop));

    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.Din;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            baud_q <= baud_end ? '0 : baud_q + BW'(1);
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        shift_q  <= head;
                        par_q    <= head_par;
                        serial_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        bit_q    <= '0;
                        serial_q <= shift_q[0];
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        if (bit_q == IW'(DATA_BITS - 1)) begin
                            bit_q <= '0;
                            if (PARITY_MODE != 0) begin
                                serial_q <= par_q;
                                state_q  <= S_PARITY;
                            end else begin
                                serial_q <= 1'b1;
                                state_q  <= S_STOP;
                            end
                        end else begin
                            shift_q  <= shift_q >> 1;
                            serial_q <= shift_q[1];
                            bit_q    <= bit_q + IW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_end) begin
                        bit_q    <= '0;
                        serial_q <= 1'b1;
                        state_q  <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Registered pulse: raise it one cycle early so it lands in the final stop cycle.
                    if (last_stop && baud_q == BW'(CLKS_PER_BIT - 2)) done_q <= 1'b1;
                    if (baud_end) begin
                        if (last_stop) begin
                            bit_q <= '0;
                            if (pop) begin
                                shift_q  <= head;
                                par_q    <= head_par;
                                serial_q <= 1'b0;
                                state_q  <= S_START;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            bit_q <= bit_q + IW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.Din_Ready  = ready;
    assign bus.Serial_Out = serial_q;
    assign bus.UBusy      = busy_q;
    assign bus.Fifo_Count = count_q;
    assign bus.Frame_Done = done_q;
endmodule
